lsu_dmem_resp: RTL and testbench

LSU_DMEM_RESP -- requirements
Module: lsu_dmem_resp

---
 rtl/lsu_pkg.sv | 73 +++++++
 rtl/lsu_dmem_rdpipe.sv | 74 +++++++
 rtl/lsu_dmem_resp.sv | 153 +++++++++++++++
 tb/tb_lsu_dmem_resp.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: access-size encoding, address width, lane helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   DMEM_ADDR_W     - width of the byte address ports
//   size_e          - access size encoding (byte/half/word/reserved)
//   req_bad()       - reserved size or misaligned offset
//   lane_mask()     - byte lanes touched by an access
//   store_lanes()   - right-aligned store data replicated onto its lanes
//   align_load()    - shift addressed bytes to bit 0 and zero-extend
package lsu_pkg;

  localparam int DMEM_ADDR_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  function automatic logic req_bad(input size_e sz, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] off);
    logic [3:0] m;
    m = 4'b0000;
    case (sz)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicating the payload means every lane already carries the right
  // byte, so the write only needs the lane mask, not a shifter.
  function automatic logic [31:0] store_lanes(input logic [31:0] d, input size_e sz);
    logic [31:0] r;
    r = d;
    case (sz)
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_HALF: r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] align_load(input logic [31:0] word, input size_e sz,
                                             input logic [1:0] off);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    case (sz)
      SZ_BYTE: r = {24'h0, sh[7:0]};
      SZ_HALF: r = {16'h0, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_dmem_rdpipe.sv
// Load-response delay line: valid/offset/size/err per stage plus the read word.
// Latency: RD_LATENCY cycles from in_vld to out_vld; word_in arrives one cycle after in_vld.
// Backpressure: none; one entry may enter every cycle, reset drops everything in flight.
//
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   in_vld/in_off/in_size/in_err - load accepted this cycle and its attributes
//   word_in                - registered array word, aligned with stage 0
//   out_vld/out_off/out_size/out_err/out_word - last stage
module lsu_dmem_rdpipe
  import lsu_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  input  logic [1:0]  in_off,
  input  logic [1:0]  in_size,
  input  logic        in_err,
  input  logic [31:0] word_in,
  output logic        out_vld,
  output logic [1:0]  out_off,
  output logic [1:0]  out_size,
  output logic        out_err,
  output logic [31:0] out_word
);

  logic       vld_q  [RD_LATENCY];
  logic [1:0] off_q  [RD_LATENCY];
  size_e      size_q [RD_LATENCY];
  logic       err_q  [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        err_q[i] <= 1'b0;
      end
    end else begin
      vld_q[0]  <= in_vld;
      off_q[0]  <= in_off;
      size_q[0] <= size_e'(in_size);
      err_q[0]  <= in_err;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        off_q[i]  <= off_q[i-1];
        size_q[i] <= size_q[i-1];
        err_q[i]  <= err_q[i-1];
      end
    end
  end

  // The array read itself is the first register stage, so the word needs
  // only RD_LATENCY-1 further stages to line up with the control fields.
  if (RD_LATENCY == 1) begin : g_lat1
    assign out_word = word_in;
  end else begin : g_latn
    logic [31:0] dat_q [RD_LATENCY-1];
    always_ff @(posedge clk) begin
      dat_q[0] <= word_in;
      for (int i = 1; i < RD_LATENCY - 1; i++) begin
        dat_q[i] <= dat_q[i-1];
      end
    end
    assign out_word = dat_q[RD_LATENCY-2];
  end

  assign out_vld  = vld_q[RD_LATENCY-1];
  assign out_off  = off_q[RD_LATENCY-1];
  assign out_size = size_q[RD_LATENCY-1];
  assign out_err  = err_q[RD_LATENCY-1];

endmodule

// File: rtl/lsu_dmem_resp.sv
// LSU data memory with byte/half/word access, fixed-latency load response and error pulses.
// Latency: loads return RD_LATENCY cycles after accept; stores commit at the end of the accept cycle.
// Backpressure: none; every cycle with rd_en or wr_en is accepted, errors signalled on err.
//
// Optional feature macro: LSU_DMEM_PERF_EN adds saturating perf counters.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   rd_en, rd_addr             - load request, byte address
//   wr_en, wr_addr, wr_data    - store request, byte address, right-aligned data
//   size                       - 00 byte, 01 half, 10 word, 11 reserved
//   rd_data, rd_valid          - zero-extended load result and its one-cycle strobe
//   err                        - one-cycle pulse for a rejected request
//   perf_rd_cnt/perf_wr_cnt/perf_err_cnt - (LSU_DMEM_PERF_EN only)
module lsu_dmem_resp
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LATENCY  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic [DMEM_ADDR_W-1:0] rd_addr,
  input  logic                   wr_en,
  input  logic [DMEM_ADDR_W-1:0] wr_addr,
  input  logic [31:0]            wr_data,
  input  logic [1:0]             size,
  output logic [31:0]            rd_data,
  output logic                   rd_valid,
  output logic                   err
`ifdef LSU_DMEM_PERF_EN
  ,
  output logic [31:0]            perf_rd_cnt,
  output logic [31:0]            perf_wr_cnt,
  output logic [31:0]            perf_err_cnt
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] mem_rdata;

  size_e            sz;
  logic             rd_acc;
  logic             wr_acc;
  logic             rd_bad;
  logic             wr_bad;
  logic             rd_ok;
  logic             wr_ok;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_mask;
  logic [31:0]      wr_lanes;
  logic             st_err_q;

  logic        pipe_vld;
  logic [1:0]  pipe_off;
  logic [1:0]  pipe_size;
  logic        pipe_err;
  logic [31:0] pipe_word;

  assign sz = size_e'(size);

  // A load issued together with a store is a protocol violation: the load
  // is dropped entirely (no pipeline entry) and reported on the store path.
  assign rd_acc = !rst && rd_en && !wr_en;
  assign wr_acc = !rst && wr_en;

  assign rd_bad = req_bad(sz, rd_addr[1:0]) || (rd_addr[DMEM_ADDR_W-1:IDX_W+2] != '0);
  assign wr_bad = req_bad(sz, wr_addr[1:0]) || (wr_addr[DMEM_ADDR_W-1:IDX_W+2] != '0);

  assign rd_ok = rd_acc && !rd_bad;
  assign wr_ok = wr_acc && !wr_bad;

  assign rd_idx   = rd_addr[IDX_W+1:2];
  assign wr_idx   = wr_addr[IDX_W+1:2];
  assign wr_mask  = lane_mask(sz, wr_addr[1:0]);
  assign wr_lanes = store_lanes(wr_data, sz);

  // Array is never reset. A store committed at an edge is visible to a
  // load read at any later edge, so back-to-back store->load needs no bypass.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_mask[l]) begin
          mem[wr_idx][8*l +: 8] <= wr_lanes[8*l +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_ok) begin
      mem_rdata <= mem[rd_idx];
    end
  end

  // Store-side error: rejected store or simultaneous load. Lands the cycle
  // after accept and is ORed with any load error emerging that same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_err_q <= 1'b0;
    end else begin
      st_err_q <= wr_acc && (wr_bad || rd_en);
    end
  end

  lsu_dmem_rdpipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rdpipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rd_acc),
    .in_off   (rd_addr[1:0]),
    .in_size  (size),
    .in_err   (rd_bad),
    .word_in  (mem_rdata),
    .out_vld  (pipe_vld),
    .out_off  (pipe_off),
    .out_size (pipe_size),
    .out_err  (pipe_err),
    .out_word (pipe_word)
  );

  // Outputs are gated by rst so they are quiet from the first reset cycle,
  // not only from the edge where the pipeline registers clear.
  assign rd_valid = pipe_vld && !rst;
  assign rd_data  = (pipe_vld && !pipe_err && !rst)
                    ? align_load(pipe_word, size_e'(pipe_size), pipe_off) : 32'h0;
  assign err      = !rst && ((pipe_vld && pipe_err) || st_err_q);

`ifdef LSU_DMEM_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rd_cnt  <= 32'h0;
      perf_wr_cnt  <= 32'h0;
      perf_err_cnt <= 32'h0;
    end else begin
      if (rd_acc && (perf_rd_cnt != 32'hFFFF_FFFF)) begin
        perf_rd_cnt <= perf_rd_cnt + 32'h1;
      end
      if (wr_acc && (perf_wr_cnt != 32'hFFFF_FFFF)) begin
        perf_wr_cnt <= perf_wr_cnt + 32'h1;
      end
      if (err && (perf_err_cnt != 32'hFFFF_FFFF)) begin
        perf_err_cnt <= perf_err_cnt + 32'h1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lsu_dmem_resp.sv
// Directed bench for lsu_dmem_resp at read latencies 1, 3 and 2 (three instances, shared stimulus).
// Inputs are driven on the falling edge; outputs are sampled on the next falling edge.
module tb_lsu_dmem_resp;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;
  localparam logic [1:0] R = 2'b11;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  size;

  // index 0: RD_LATENCY=1, index 1: RD_LATENCY=2, index 2: RD_LATENCY=3
  logic        rv [3];
  logic [31:0] rd [3];
  logic        er [3];
`ifdef LSU_DMEM_PERF_EN
  logic [31:0] prd [3];
  logic [31:0] pwr [3];
  logic [31:0] perr [3];
`endif

  int checks = 0;
  int errors = 0;

  lsu_dmem_resp #(.DEPTH_WORDS(1024), .RD_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .size(size),
    .rd_data(rd[0]), .rd_valid(rv[0]), .err(er[0])
`ifdef LSU_DMEM_PERF_EN
    , .perf_rd_cnt(prd[0]), .perf_wr_cnt(pwr[0]), .perf_err_cnt(perr[0])
`endif
  );

  lsu_dmem_resp #(.DEPTH_WORDS(1024), .RD_LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .size(size),
    .rd_data(rd[1]), .rd_valid(rv[1]), .err(er[1])
`ifdef LSU_DMEM_PERF_EN
    , .perf_rd_cnt(prd[1]), .perf_wr_cnt(pwr[1]), .perf_err_cnt(perr[1])
`endif
  );

  lsu_dmem_resp #(.DEPTH_WORDS(1024), .RD_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .size(size),
    .rd_data(rd[2]), .rd_valid(rv[2]), .err(er[2])
`ifdef LSU_DMEM_PERF_EN
    , .perf_rd_cnt(prd[2]), .perf_wr_cnt(pwr[2]), .perf_err_cnt(perr[2])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] s);
    rd_en   = 1'b1;
    rd_addr = a;
    wr_en   = 1'b0;
    size    = s;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    rd_en   = 1'b0;
    size    = s;
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
    rd_addr = 32'h0; wr_addr = 32'h0; wr_data = 32'h0; size = W;

    // ---- reset state
    tick(); tick();
    chk("rst_rd_valid", {29'h0, rv[2], rv[1], rv[0]}, 32'h0);
    chk("rst_rd_data", rd[0] | rd[1] | rd[2], 32'h0);
    chk("rst_err", {29'h0, er[2], er[1], er[0]}, 32'h0);
    rst = 1'b0;
    tick();

    // ---- word store then word load the next cycle
    store(32'h10, 32'hDEAD_BEEF, W); tick();
    chk("st_word_no_err", {31'h0, er[0]}, 32'h0);
    load(32'h10, W); tick();
    chk("ld_word_valid", {31'h0, rv[0]}, 32'h1);
    chk("ld_word_data", rd[0], 32'hDEAD_BEEF);
    idle(); tick();
    chk("idle_valid_low", {31'h0, rv[0]}, 32'h0);
    chk("idle_data_zero", rd[0], 32'h0);

    // ---- byte store 0xAA to 0x13 -> word 0x10 = 0xAAADBEEF (little-endian lanes)
    store(32'h13, 32'h0000_00AA, B); tick();
    load(32'h12, H); tick();
    chk("ld_half_12", rd[0], 32'h0000_AAAD);
    load(32'h11, B); tick();
    chk("ld_byte_11", rd[0], 32'h0000_00BE);

    // ---- rejected requests
    store(32'h20, 32'h1234_5678, W); tick();
    load(32'h21, H); tick();
    chk("mis_half_valid", {31'h0, rv[0]}, 32'h1);
    chk("mis_half_data", rd[0], 32'h0);
    chk("mis_half_err", {31'h0, er[0]}, 32'h1);
    store(32'h22, 32'hFFFF_FFFF, W); tick();
    chk("mis_word_st_err", {31'h0, er[0]}, 32'h1);
    chk("mis_word_st_novld", {31'h0, rv[0]}, 32'h0);
    load(32'h20, W); tick();
    chk("word20_unchanged", rd[0], 32'h1234_5678);
    chk("word20_no_err", {31'h0, er[0]}, 32'h0);
    load(32'h0, R); tick();
    chk("rsvd_ld_err", {30'h0, er[0], rv[0]}, 32'h3);
    chk("rsvd_ld_data", rd[0], 32'h0);
    store(32'h1000, 32'hCAFE_F00D, W); tick();
    chk("oob_st_err", {31'h0, er[0]}, 32'h1);
    store(32'hFFC, 32'hCAFE_F00D, W); tick();
    chk("last_word_st_ok", {31'h0, er[0]}, 32'h0);
    load(32'hFFC, W); tick();
    chk("last_word_ld", rd[0], 32'hCAFE_F00D);
    load(32'h1000, W); tick();
    chk("oob_ld_err", {30'h0, er[0], rv[0]}, 32'h3);
    chk("oob_ld_data", rd[0], 32'h0);
    idle(); tick();
    chk("err_is_pulse", {31'h0, er[0]}, 32'h0);

    // ---- back-to-back loads, latency 1 and 3
    store(32'h0, 32'h0302_0100, W); tick();
    store(32'h4, 32'h0706_0504, W); tick();
    store(32'h8, 32'h0B0A_0908, W); tick();
    store(32'hC, 32'h0F0E_0D0C, W); tick();
    load(32'h0, W); tick();
    chk("b2b_l1_0", rd[0], 32'h0302_0100);
    chk("b2b_l3_wait1", {31'h0, rv[2]}, 32'h0);
    load(32'h4, W); tick();
    chk("b2b_l1_1", rd[0], 32'h0706_0504);
    chk("b2b_l3_wait2", {31'h0, rv[2]}, 32'h0);
    load(32'h8, W); tick();
    chk("b2b_l1_2", rd[0], 32'h0B0A_0908);
    chk("b2b_l3_vld0", {31'h0, rv[2]}, 32'h1);
    chk("b2b_l3_dat0", rd[2], 32'h0302_0100);
    load(32'hC, W); tick();
    chk("b2b_l1_3", rd[0], 32'h0F0E_0D0C);
    chk("b2b_l3_dat1", {rv[2] ? rd[2] : 32'hFFFF_FFFF}, 32'h0706_0504);
    idle(); tick();
    chk("b2b_l3_dat2", {rv[2] ? rd[2] : 32'hFFFF_FFFF}, 32'h0B0A_0908);
    tick();
    chk("b2b_l3_dat3", {rv[2] ? rd[2] : 32'hFFFF_FFFF}, 32'h0F0E_0D0C);
    tick();
    chk("b2b_l3_done", {31'h0, rv[2]}, 32'h0);

    // ---- rd_en and wr_en together
    rd_en = 1'b1; rd_addr = 32'h40;
    wr_en = 1'b1; wr_addr = 32'h40; wr_data = 32'h0000_0055; size = W;
    tick();
    chk("both_err_l1", {31'h0, er[0]}, 32'h1);
    chk("both_err_l3", {31'h0, er[2]}, 32'h1);
    chk("both_novld_l1", {31'h0, rv[0]}, 32'h0);
    load(32'h40, W); tick();
    chk("both_store_done", rd[0], 32'h0000_0055);
    idle(); tick();
    chk("both_novld_l3", {31'h0, rv[2]}, 32'h0);
    tick();
    chk("both_store_l3", {rv[2] ? rd[2] : 32'hFFFF_FFFF}, 32'h0000_0055);

    // ---- reset one cycle after a load (latency 2); store during reset ignored
    load(32'h10, W); tick();
    rst = 1'b1;
    store(32'h10, 32'h0, W); tick();
    chk("rst_mid_vld", {29'h0, rv[2], rv[1], rv[0]}, 32'h0);
    chk("rst_mid_err", {29'h0, er[2], er[1], er[0]}, 32'h0);
`ifdef LSU_DMEM_PERF_EN
    chk("perf_rd_zero", prd[1], 32'h0);
    chk("perf_wr_zero", pwr[1], 32'h0);
    chk("perf_err_zero", perr[1], 32'h0);
`endif
    tick();
    rst = 1'b0; idle(); tick();
    chk("post_rst_l2_a", {31'h0, rv[1]}, 32'h0);
    tick();
    chk("post_rst_l2_b", {30'h0, rv[2], rv[1]}, 32'h0);
    load(32'h10, W); tick();
    chk("mem_kept_over_rst", rd[0], 32'hAAAD_BEEF);
    idle(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
